// File: rtl/dbg_trace_unit.sv
// Retire-trace ring buffer plus halt controller; halt and read responses land one cycle after cause.
// No backpressure: reads return every cycle they are requested, retires outside RUN are dropped.
module dbg_trace_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int NBRK  = 4,
  parameter int CYC_W = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 stop,
  input  logic                 retire_valid,
  input  logic [XLEN-1:0]      retire_pc,
  input  logic [XLEN-1:0]      retire_instr,
  input  logic [NBRK-1:0]      brk_en,
  input  logic [NBRK*XLEN-1:0] brk_pc,
  input  logic [CYC_W-1:0]     cyc_limit,
  input  logic                 rd_req,
  input  logic [AW-1:0]        rd_idx,
  output logic                 rd_valid,
  output logic                 rd_hit,
  output logic [XLEN-1:0]      rd_pc,
  output logic [XLEN-1:0]      rd_instr,
  output logic                 running,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [2:0]           halt_brk_id,
  output logic [AW:0]          trace_count,
  output logic [CYC_W-1:0]     cyc_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BRK  = 2'd1;
  localparam logic [1:0] CAUSE_EXT  = 2'd2;
  localparam logic [1:0] CAUSE_TMO  = 2'd3;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       trace_count_q, trace_count_d;
  logic [CYC_W-1:0]  cyc_count_q, cyc_count_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic [2:0]        halt_brk_id_q, halt_brk_id_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_hit_q, rd_hit_d;
  logic [XLEN-1:0]   rd_pc_q, rd_pc_d;
  logic [XLEN-1:0]   rd_instr_q, rd_instr_d;

  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [XLEN-1:0]   instr_mem [DEPTH];

  logic              brk_hit;
  logic [2:0]        brk_id;
  logic              tmo_hit;
  logic              trig_any;
  logic              mem_we;
  logic [AW-1:0]     rd_addr;

  // Descending scan so the lowest matching comparator wins.
  always_comb begin
    brk_hit = 1'b0;
    brk_id  = 3'd0;
    for (int i = NBRK - 1; i >= 0; i--) begin
      if (retire_valid && brk_en[i] && (retire_pc == brk_pc[i*XLEN +: XLEN])) begin
        brk_hit = 1'b1;
        brk_id  = 3'(i);
      end
    end
  end

  assign tmo_hit  = (cyc_limit != '0) &&
                    (({1'b0, cyc_count_q} + (CYC_W+1)'(1)) == {1'b0, cyc_limit});
  assign trig_any = brk_hit || stop || tmo_hit;
  assign mem_we   = (state_q == ST_RUN) && !arm && retire_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm)                                 state_d = ST_RUN;
    else if (state_q == ST_RUN && trig_any)  state_d = ST_HALTED;
  end

  always_comb begin
    running = (state_q == ST_RUN);
    halted  = (state_q == ST_HALTED);
  end

  // arm wins over any activity in its own cycle, including a trigger.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    trace_count_d = trace_count_q;
    cyc_count_d   = cyc_count_q;
    halt_cause_d  = halt_cause_q;
    halt_brk_id_d = halt_brk_id_q;
    if (arm) begin
      wr_ptr_d      = '0;
      trace_count_d = '0;
      cyc_count_d   = '0;
      halt_cause_d  = CAUSE_NONE;
      halt_brk_id_d = 3'd0;
    end else if (state_q == ST_RUN) begin
      if (cyc_count_q != '1) cyc_count_d = cyc_count_q + CYC_W'(1);
      if (retire_valid) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (trace_count_q != (AW+1)'(DEPTH)) trace_count_d = trace_count_q + (AW+1)'(1);
      end
      if (brk_hit) begin
        halt_cause_d  = CAUSE_BRK;
        halt_brk_id_d = brk_id;
      end else if (stop) begin
        halt_cause_d  = CAUSE_EXT;
      end else if (tmo_hit) begin
        halt_cause_d  = CAUSE_TMO;
      end
    end
  end

  // Oldest entry sits trace_count slots behind the write pointer; a full buffer truncates to wr_ptr.
  always_comb begin
    rd_addr    = wr_ptr_q - trace_count_q[AW-1:0] + rd_idx;
    rd_valid_d = rd_req;
    rd_hit_d   = rd_req && !arm && ({1'b0, rd_idx} < trace_count_q);
    rd_pc_d    = rd_hit_d ? pc_mem[rd_addr]    : '0;
    rd_instr_d = rd_hit_d ? instr_mem[rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem[wr_ptr_q]    <= retire_pc;
      instr_mem[wr_ptr_q] <= retire_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      trace_count_q <= '0;
      cyc_count_q   <= '0;
      halt_cause_q  <= CAUSE_NONE;
      halt_brk_id_q <= 3'd0;
      rd_valid_q    <= 1'b0;
      rd_hit_q      <= 1'b0;
      rd_pc_q       <= '0;
      rd_instr_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      trace_count_q <= trace_count_d;
      cyc_count_q   <= cyc_count_d;
      halt_cause_q  <= halt_cause_d;
      halt_brk_id_q <= halt_brk_id_d;
      rd_valid_q    <= rd_valid_d;
      rd_hit_q      <= rd_hit_d;
      rd_pc_q       <= rd_pc_d;
      rd_instr_q    <= rd_instr_d;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_hit      = rd_hit_q;
  assign rd_pc       = rd_pc_q;
  assign rd_instr    = rd_instr_q;
  assign halt_cause  = halt_cause_q;
  assign halt_brk_id = halt_brk_id_q;
  assign trace_count = trace_count_q;
  assign cyc_count   = cyc_count_q;

endmodule

// File: tb/tb_dbg_trace_unit.sv
// Directed bench for dbg_trace_unit: status checked inline, read responses via scoreboard queue.
module tb_dbg_trace_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int NBRK  = 4;
  localparam int CYC_W = 16;
  localparam int AW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 arm, stop, retire_valid, rd_req;
  logic [XLEN-1:0]      retire_pc, retire_instr;
  logic [NBRK-1:0]      brk_en;
  logic [NBRK*XLEN-1:0] brk_pc;
  logic [CYC_W-1:0]     cyc_limit;
  logic [AW-1:0]        rd_idx;
  logic                 rd_valid, rd_hit, running, halted;
  logic [XLEN-1:0]      rd_pc, rd_instr;
  logic [1:0]           halt_cause;
  logic [2:0]           halt_brk_id;
  logic [AW:0]          trace_count;
  logic [CYC_W-1:0]     cyc_count;

  typedef struct packed {
    logic        hit;
    logic [31:0] pc;
    logic [31:0] instr;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dbg_trace_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .NBRK(NBRK), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .brk_en(brk_en), .brk_pc(brk_pc), .cyc_limit(cyc_limit),
    .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .running(running), .halted(halted), .halt_cause(halt_cause), .halt_brk_id(halt_brk_id),
    .trace_count(trace_count), .cyc_count(cyc_count)
  );

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    retire_valid = 1'b1;
    retire_pc    = pc;
    retire_instr = ins(pc);
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] idx, input logic hit, input logic [31:0] pc);
    rsp_t e;
    e.hit   = hit;
    e.pc    = hit ? pc : 32'h0;
    e.instr = hit ? ins(pc) : 32'h0;
    exp_q.push_back(e);
    rd_req = 1'b1;
    rd_idx = idx;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic run, input logic hlt,
                            input logic [1:0] cause, input logic [2:0] id);
    chk({tag, "_running"}, running, run);
    chk({tag, "_halted"},  halted,  hlt);
    chk({tag, "_cause"},   halt_cause, cause);
    chk({tag, "_brk_id"},  halt_brk_id, id);
  endtask

  // Monitor: every read response is matched against the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got rd_valid=1 with pc 0x%0h expected no response", rd_pc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_hit",   rd_hit,   e.hit);
        chk("rd_pc",    rd_pc,    e.pc);
        chk("rd_instr", rd_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; retire_valid = 1'b0; rd_req = 1'b0;
    retire_pc = '0; retire_instr = '0; brk_en = '0; brk_pc = '0; cyc_limit = '0; rd_idx = '0;
    tick();
    tick();
    chk_status("reset", 1'b0, 1'b0, 2'd0, 3'd0);
    chk("reset_trace_count", trace_count, 0);
    chk("reset_cyc_count", cyc_count, 0);
    chk("reset_rd_valid", rd_valid, 0);
    rst = 1'b0;
    tick();

    // 1: short trace, in-range and out-of-range reads
    do_arm();
    chk("t1_running", running, 1);
    chk("t1_cyc0", cyc_count, 0);
    for (int i = 0; i < 5; i++) retire(32'(i * 4));
    chk("t1_trace_count", trace_count, 5);
    rd(4'd0, 1'b1, 32'h00);
    rd(4'd4, 1'b1, 32'h10);
    rd(4'd5, 1'b0, 32'h00);
    rd(4'd2, 1'b1, 32'h08);

    // 2: wrap-around, oldest-first indexing, read-during-write
    do_arm();
    for (int i = 0; i < 20; i++) retire(32'(i * 4));
    chk("t2_trace_count", trace_count, 16);
    rd(4'd0,  1'b1, 32'h10);
    rd(4'd15, 1'b1, 32'h4C);
    rd(4'd7,  1'b1, 32'h2C);
    retire_valid = 1'b1; retire_pc = 32'h50; retire_instr = ins(32'h50);
    rd(4'd15, 1'b1, 32'h4C);
    retire_valid = 1'b0;
    rd(4'd15, 1'b1, 32'h50);
    rd(4'd0,  1'b1, 32'h14);

    // 3: breakpoint, lowest enabled match wins, disabled comparators ignored
    brk_en = 4'b0110;
    brk_pc[0*XLEN +: XLEN] = 32'h190;
    brk_pc[1*XLEN +: XLEN] = 32'h198;
    brk_pc[2*XLEN +: XLEN] = 32'h198;
    brk_pc[3*XLEN +: XLEN] = 32'h194;
    do_arm();
    retire(32'h190);
    chk_status("t3_pre", 1'b1, 1'b0, 2'd0, 3'd0);
    retire(32'h194);
    retire(32'h198);
    chk_status("t3_brk", 1'b0, 1'b1, 2'd1, 3'd1);
    chk("t3_trace_count", trace_count, 3);
    chk("t3_cyc", cyc_count, 3);
    retire(32'h19C);
    chk("t3_no_record", trace_count, 3);
    rd(4'd2, 1'b1, 32'h198);
    rd(4'd3, 1'b0, 32'h0);
    chk("t3_cyc_frozen", cyc_count, 3);

    // 6: re-arm from HALTED
    brk_en = '0;
    do_arm();
    chk_status("t6", 1'b1, 1'b0, 2'd0, 3'd0);
    chk("t6_trace_count", trace_count, 0);
    chk("t6_cyc0", cyc_count, 0);
    repeat (3) tick();
    chk("t6_cyc3", cyc_count, 3);

    // 4: cycle-limit timeout, then priority with simultaneous triggers
    cyc_limit = 16'd10;
    do_arm();
    repeat (9) tick();
    chk("t4_run9", running, 1);
    chk("t4_cyc9", cyc_count, 9);
    tick();
    chk_status("t4_tmo", 1'b0, 1'b1, 2'd3, 3'd0);
    chk("t4_cyc10", cyc_count, 10);
    repeat (3) tick();
    chk("t4_cyc_frozen", cyc_count, 10);

    brk_en = 4'b0001;
    brk_pc[0*XLEN +: XLEN] = 32'h300;
    do_arm();
    repeat (9) tick();
    stop = 1'b1;
    retire(32'h300);
    stop = 1'b0;
    chk_status("t4_prio", 1'b0, 1'b1, 2'd1, 3'd0);
    chk("t4_prio_cyc", cyc_count, 10);

    cyc_limit = '0;
    brk_en    = '0;
    do_arm();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_status("t4_ext", 1'b0, 1'b1, 2'd2, 3'd0);
    chk("t4_ext_cyc", cyc_count, 1);

    // 5: reset mid-RUN drops a pending read and clears everything
    do_arm();
    for (int i = 0; i < 7; i++) retire(32'h400 + 32'(i * 4));
    chk("t5_trace7", trace_count, 7);
    rd_req = 1'b1; rd_idx = 4'd0; rst = 1'b1;
    tick();
    rd_req = 1'b0; rst = 1'b0;
    chk_status("t5_rst", 1'b0, 1'b0, 2'd0, 3'd0);
    chk("t5_rst_trace", trace_count, 0);
    chk("t5_rst_cyc", cyc_count, 0);
    chk("t5_rst_rd_valid", rd_valid, 0);
    retire(32'h500);
    chk("t5_idle_ignore", trace_count, 0);
    do_arm();
    retire(32'h600);
    chk("t5_trace1", trace_count, 1);
    rd(4'd0, 1'b1, 32'h600);

    // arm coinciding with a read returns a miss
    arm = 1'b1;
    rd(4'd0, 1'b0, 32'h0);
    arm = 1'b0;
    chk("arm_rd_trace", trace_count, 0);

    // back-to-back reads
    retire(32'h700);
    retire(32'h704);
    rd(4'd0, 1'b1, 32'h700);
    rd(4'd1, 1'b1, 32'h704);
    rd(4'd2, 1'b0, 32'h0);

    repeat (3) tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
